// File: rtl/sdram_request_adapter.sv
// Client-side front end for the 4M x 16 SDRAM controller: buffers one valid/ready
// request, drives the controller's level-held command, and packs burst beats.
module sdram_request_adapter #(
    parameter int BURST_LENGTH = 1,
    parameter int ADDR_WIDTH   = 22
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_address,
    input  logic [16*BURST_LENGTH-1:0] req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [16*BURST_LENGTH-1:0] rsp_data,
    output logic                      wr_complete,
    output logic [1:0]                command,
    output logic [ADDR_WIDTH-1:0]     data_address,
    output logic [15:0]               data_write,
    input  logic [15:0]               data_read,
    input  logic                      data_read_valid,
    input  logic                      data_write_done
);

    localparam int DW = 16 * BURST_LENGTH;
    localparam int IW = $clog2(BURST_LENGTH) + 1;
    localparam logic [IW-1:0] LAST_BEAT = IW'(BURST_LENGTH - 1);
    localparam logic [IW-1:0] BEAT_CNT  = IW'(BURST_LENGTH);

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WBURST,
        ST_RBURST,
        ST_RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  buf_write_q;
    logic [ADDR_WIDTH-1:0] buf_addr_q;
    logic [DW-1:0]         buf_wdata_q;
    logic                  op_write_q, op_write_d;
    logic [DW-1:0]         wbeats_q, wbeats_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           dwr_q, dwr_d;
    logic [DW-1:0]         rsp_data_q, rsp_data_d;
    logic                  wr_complete_q, wr_complete_d;
    logic                  accept;
    logic [IW-1:0]         idx_next;

    // Valid/ready: a transfer happens on a rising edge where both are high; the
    // sender holds valid and payload stable until then, and ready never depends on valid.
    assign rsp_valid = (state_q == ST_RESP);
    assign req_ready = !reset && !buf_valid_q && !(rsp_valid && !rsp_ready);
    assign accept    = req_valid && req_ready;

    assign command      = cmd_q;
    assign data_address = addr_q;
    assign data_write   = dwr_q;
    assign rsp_data     = rsp_data_q;
    assign wr_complete  = wr_complete_q;

    function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] i);
        return (i >= LAST_BEAT) ? LAST_BEAT : i + 1'b1;
    endfunction

    function automatic logic [15:0] beat_of(input logic [DW-1:0] beats, input logic [IW-1:0] i);
        return beats[16*int'(i) +: 16];
    endfunction

    always_comb begin
        state_d       = state_q;
        buf_valid_d   = buf_valid_q;
        op_write_d    = op_write_q;
        wbeats_d      = wbeats_q;
        idx_d         = idx_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        dwr_d         = dwr_q;
        rsp_data_d    = rsp_data_q;
        wr_complete_d = 1'b0;
        idx_next      = sat_inc(idx_q);

        if (accept) begin
            buf_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (buf_valid_q) begin
                    addr_d      = buf_addr_q;
                    dwr_d       = buf_wdata_q[15:0];
                    cmd_d       = buf_write_q ? CMD_WRITE : CMD_READ;
                    op_write_d  = buf_write_q;
                    wbeats_d    = buf_wdata_q;
                    idx_d       = '0;
                    buf_valid_d = 1'b0;
                    state_d     = ST_ISSUE;
                    // Beats the controller never delivers must read back as zero.
                    if (!buf_write_q) begin
                        rsp_data_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (op_write_q && data_write_done) begin
                    cmd_d   = CMD_IDLE;
                    idx_d   = sat_inc('0);
                    dwr_d   = beat_of(wbeats_q, sat_inc('0));
                    state_d = ST_WBURST;
                end else if (!op_write_q && data_read_valid) begin
                    cmd_d            = CMD_IDLE;
                    rsp_data_d[15:0] = data_read;
                    idx_d            = IW'(1);
                    state_d          = ST_RBURST;
                end
            end
            ST_WBURST: begin
                if (data_write_done) begin
                    idx_d = idx_next;
                    dwr_d = beat_of(wbeats_q, idx_next);
                end else begin
                    dwr_d         = '0;
                    wr_complete_d = 1'b1;
                    idx_d         = '0;
                    state_d       = ST_IDLE;
                end
            end
            ST_RBURST: begin
                if (data_read_valid) begin
                    if (idx_q < BEAT_CNT) begin
                        rsp_data_d[16*int'(idx_q) +: 16] = data_read;
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            buf_valid_q   <= 1'b0;
            buf_write_q   <= 1'b0;
            buf_addr_q    <= '0;
            buf_wdata_q   <= '0;
            op_write_q    <= 1'b0;
            wbeats_q      <= '0;
            idx_q         <= '0;
            cmd_q         <= CMD_IDLE;
            addr_q        <= '0;
            dwr_q         <= '0;
            rsp_data_q    <= '0;
            wr_complete_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_valid_q   <= buf_valid_d;
            op_write_q    <= op_write_d;
            wbeats_q      <= wbeats_d;
            idx_q         <= idx_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            dwr_q         <= dwr_d;
            rsp_data_q    <= rsp_data_d;
            wr_complete_q <= wr_complete_d;
            if (accept) begin
                buf_write_q <= req_write;
                buf_addr_q  <= req_address;
                buf_wdata_q <= req_wdata;
            end
        end
    end

endmodule
